// File: rtl/mem_responder.sv
// mem_responder: memory-side responder owning MAR, MBR and the storage array.
// Serves one read or write per request handshake after WAIT_STATES stall cycles.
// Optional build macro MEM_PARITY_EN adds an even-parity bit per array entry,
// the mem_perr_inj input and a live mem_err output; without it mem_err is 0.
module mem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              mem_clk,
    input  logic              mem_rst_n,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
`ifdef MEM_PARITY_EN
    input  logic              mem_perr_inj,
`endif
    output logic              mem_busy,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
`ifdef MEM_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif
    localparam logic [3:0]  WS_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mbr;
    logic [3:0]        cnt;
    logic              we_q;
    logic [WORD_W-1:0] mem_array [DEPTH];
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;
`ifdef MEM_PARITY_EN
    logic              inj_q;
`endif

    // Form the stored word from MBR (plus its parity bit when enabled) and fetch the addressed entry
    always_comb begin
`ifdef MEM_PARITY_EN
        wr_word = {(^mbr) ^ inj_q, mbr};
`else
        wr_word = mbr;
`endif
        rd_word = mem_array[mar];
    end

    // Storage array write; only the ACCESS state of a write touches the array, so a reset
    // that has already forced IDLE leaves the contents untouched
    always_ff @(posedge mem_clk) begin
        if (state == ST_ACCESS && we_q) begin
            mem_array[mar] <= wr_word;
        end
    end

    // Handshake FSM with registered MAR/MBR/busy/ack/rdata/err
    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            state     <= ST_IDLE;
            mar       <= '0;
            mbr       <= '0;
            cnt       <= '0;
            we_q      <= 1'b0;
            mem_busy  <= 1'b0;
            mem_ack   <= 1'b0;
            mem_rdata <= '0;
            mem_err   <= 1'b0;
`ifdef MEM_PARITY_EN
            inj_q     <= 1'b0;
`endif
        end else begin
            mem_ack <= 1'b0;
            mem_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_req) begin
                        mar      <= mem_addr;
                        we_q     <= mem_we;
                        if (mem_we) begin
                            mbr <= mem_wdata;
                        end
`ifdef MEM_PARITY_EN
                        inj_q    <= mem_perr_inj;
`endif
                        mem_busy <= 1'b1;
                        cnt      <= WS_CNT;
                        state    <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // ack/rdata/err are loaded here so they are visible for exactly the RESP cycle
                    if (!we_q) begin
                        mbr       <= rd_word[DATA_W-1:0];
                        mem_rdata <= rd_word[DATA_W-1:0];
`ifdef MEM_PARITY_EN
                        mem_err   <= ^rd_word;
`endif
                    end
                    mem_ack <= 1'b1;
                    state   <= ST_RESP;
                end
                ST_RESP: begin
                    mem_busy <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_STATES=0 and WAIT_STATES=3) driven through
// a shared bus with a per-instance request gate; a flat array model predicts read data.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic       we;
    logic       sel;
    logic [7:0] addr;
    logic [7:0] wdata;
`ifdef MEM_PARITY_EN
    logic       perr_inj;
`endif

    logic       req0, req1;
    logic       busy0, busy1, ack0, ack1, err0, err1;
    logic [7:0] rdata0, rdata1;
    logic       busy_o, ack_o, err_o;
    logic [7:0] rdata_o;

    assign req0    = req & ~sel;
    assign req1    = req & sel;
    assign busy_o  = sel ? busy1 : busy0;
    assign ack_o   = sel ? ack1 : ack0;
    assign err_o   = sel ? err1 : err0;
    assign rdata_o = sel ? rdata1 : rdata0;

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0)) u_ws0 (
        .mem_clk(clk), .mem_rst_n(rst_n), .mem_req(req0), .mem_we(we),
        .mem_addr(addr), .mem_wdata(wdata),
`ifdef MEM_PARITY_EN
        .mem_perr_inj(perr_inj),
`endif
        .mem_busy(busy0), .mem_ack(ack0), .mem_rdata(rdata0), .mem_err(err0)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(3)) u_ws3 (
        .mem_clk(clk), .mem_rst_n(rst_n), .mem_req(req1), .mem_we(we),
        .mem_addr(addr), .mem_wdata(wdata),
`ifdef MEM_PARITY_EN
        .mem_perr_inj(perr_inj),
`endif
        .mem_busy(busy1), .mem_ack(ack1), .mem_rdata(rdata1), .mem_err(err1)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] model   [2][256];
    bit         valid   [2][256];
    bit         pbad    [2][256];
    logic [7:0] last_rd [2];

    // One full transaction on the selected instance. Accept edge is edge 1; ack must appear
    // after edge WS+2 and the responder must be idle after edge WS+3.
    task automatic run_txn(input bit w, input logic [7:0] a, input logic [7:0] d,
                           input bit inj, input bit hold, input bit ghost, input string name);
        int         s;
        int         n_ws;
        logic [7:0] exp_rd;
        bit         exp_err;
        s      = sel ? 1 : 0;
        n_ws   = sel ? 3 : 0;
        exp_rd = w ? last_rd[s] : model[s][a];
`ifdef MEM_PARITY_EN
        exp_err = !w && pbad[s][a];
`else
        exp_err = 1'b0;
`endif
        req = 1'b1; we = w; addr = a; wdata = d;
`ifdef MEM_PARITY_EN
        perr_inj = inj;
`endif
        @(posedge clk); #1;
        vectors++;
        if (busy_o !== 1'b1 || ack_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s accept: busy=%b ack=%b, required busy=1 ack=0", name, busy_o, ack_o);
        end
        // post-acceptance input changes must not matter
        req = hold; we = $urandom_range(0, 1); addr = 8'($urandom); wdata = 8'($urandom);
        for (int k = 2; k <= n_ws + 2; k++) begin
            @(posedge clk); #1;
            if (ghost && k == 2) req = 1'b1;
            vectors++;
            if (busy_o !== 1'b1 || ack_o !== (k == n_ws + 2)) begin
                miscompares++;
                $display("FAIL %s edge%0d: busy=%b ack=%b, required busy=1 ack=%b",
                         name, k, busy_o, ack_o, (k == n_ws + 2));
            end
            if (k == n_ws + 2) begin
                vectors++;
                if (rdata_o !== exp_rd || err_o !== exp_err) begin
                    miscompares++;
                    $display("FAIL %s data: rdata=%02h err=%b, required rdata=%02h err=%b",
                             name, rdata_o, err_o, exp_rd, exp_err);
                end
                if (ghost) req = 1'b0;
            end
        end
        @(posedge clk); #1;
        vectors++;
        if (busy_o !== 1'b0 || ack_o !== 1'b0 || err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle: busy=%b ack=%b err=%b, required 0 0 0", name, busy_o, ack_o, err_o);
        end
        if (w) begin
            model[s][a] = d; valid[s][a] = 1'b1; pbad[s][a] = inj;
        end else begin
            last_rd[s] = exp_rd;
        end
    endtask

    task automatic check_zero_outputs(input string name);
        vectors++;
        if ({busy0, ack0, err0, rdata0, busy1, ack1, err1, rdata1} !== '0) begin
            miscompares++;
            $display("FAIL %s: ws0 busy=%b ack=%b err=%b rdata=%02h ws3 busy=%b ack=%b err=%b rdata=%02h, required all 0",
                     name, busy0, ack0, err0, rdata0, busy1, ack1, err1, rdata1);
        end
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; we = 1'b0; sel = 1'b0; addr = '0; wdata = '0;
`ifdef MEM_PARITY_EN
        perr_inj = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset_state");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        sel = 1'b0;
        run_txn(1, 8'h3C, 8'hA5, 0, 0, 0, "ws0_wr_3C");
        run_txn(0, 8'h3C, 8'h00, 0, 0, 0, "ws0_rd_3C");
        sel = 1'b1;
        run_txn(1, 8'h10, 8'h5A, 0, 0, 1, "ws3_wr_10_ghost");
        run_txn(0, 8'h10, 8'h00, 0, 0, 1, "ws3_rd_10_ghost");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 2; i++) begin
            sel = (i == 1);
            run_txn(1, 8'hFF, 8'hFF, 0, 0, 0, "wr_top");
            run_txn(1, 8'h00, 8'h01, 0, 0, 0, "wr_bottom");
            run_txn(0, 8'hFF, 8'h00, 0, 0, 0, "rd_top");
            run_txn(0, 8'h00, 8'h00, 0, 0, 0, "rd_bottom");
        end
    endtask

    task automatic test_reset_abort();
        // reset while the WAIT_STATES=3 instance is stalling a write
        sel = 1'b1;
        run_txn(1, 8'h20, 8'h11, 0, 0, 0, "pre_wr_20");
        req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 8'h77;
        @(posedge clk); #1; req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        check_zero_outputs("reset_in_wait");
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) rst_n = 1'b1;
            vectors++;
            if (ack1 !== 1'b0 || busy1 !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_wait_cyc%0d: ack=%b busy=%b, required 0 0", k, ack1, busy1);
            end
        end
        run_txn(0, 8'h20, 8'h00, 0, 0, 0, "rd_20_after_abort");
        // reset while the WAIT_STATES=0 instance sits in ACCESS, before the writing edge
        sel = 1'b0;
        run_txn(1, 8'h21, 8'h22, 0, 0, 0, "pre_wr_21");
        req = 1'b1; we = 1'b1; addr = 8'h21; wdata = 8'h99;
        @(posedge clk); #1; req = 1'b0;
        rst_n = 1'b0; #1;
        check_zero_outputs("reset_in_access");
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        run_txn(0, 8'h21, 8'h00, 0, 0, 0, "rd_21_after_abort");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            sel = (i == 1);
            for (int t = 0; t < 8; t++) begin
                run_txn((t % 2) == 0, 8'h05, 8'($urandom), 0, (t < 7), 0, "b2b_05");
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2; i++) begin
            sel = (i == 1);
            for (int t = 0; t < 24; t++) begin
                logic [7:0] a;
                bit         w;
                a = 8'h80 + 8'($urandom_range(0, 7));
                w = !valid[i][a] || ($urandom_range(0, 1) == 1);
                run_txn(w, a, 8'($urandom), $urandom_range(0, 3) == 0, 0, 0, "random");
            end
        end
    endtask

`ifdef MEM_PARITY_EN
    task automatic test_parity();
        for (int i = 0; i < 2; i++) begin
            sel = (i == 1);
            run_txn(1, 8'h40, 8'h33, 1, 0, 0, "par_wr_inj");
            run_txn(0, 8'h40, 8'h00, 0, 0, 0, "par_rd_bad");
            run_txn(1, 8'h41, 8'h33, 0, 0, 0, "par_wr_clean");
            run_txn(0, 8'h41, 8'h00, 0, 0, 0, "par_rd_clean");
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_reset_abort();
        test_back_to_back();
        test_random();
`ifdef MEM_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
